// File: rtl/pe_sched_arbiter_pkg.sv
// Shared PE definitions: opcode class encodings, default result latency
// and small sizing helpers used by the scheduler/arbiter slice.
package pe_pkg;

    // Default PE result latency in cycles, counted from the issue edge.
    localparam int unsigned PeLat = 1;

    // Opcode class lives in opcode[31:25].
    localparam logic [6:0] ClsArith = 7'b0000001;
    localparam logic [6:0] ClsFpu   = 7'b0000010;
    localparam logic [6:0] ClsComp  = 7'b0010000;

    function automatic logic [6:0] opcode_class(input logic [31:0] opcode);
        return opcode[31:25];
    endfunction

    // Index width for a requester count; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_sched_arbiter_if.sv
// Request/response handshake and PE issue/result bus shared between the
// requester side (master) and the scheduler/arbiter (slave).
interface pe_sched_arbiter_if #(
    parameter int unsigned NREQ = 4
) ();

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_opcode;
    logic [NREQ*32-1:0] req_op1;
    logic [NREQ*32-1:0] req_op2;
    logic [NREQ*32-1:0] req_op3;

    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [NREQ*32-1:0] rsp_data;
    logic [NREQ-1:0]    rsp_err;

    logic               pe_valid_in;
    logic [31:0]        pe_opcode;
    logic [31:0]        pe_op1;
    logic [31:0]        pe_op2;
    logic [31:0]        pe_op3;
    logic [31:0]        pe_result;
    logic               pe_result_valid;

    // Requesters plus the PE core: drive requests, response ready and results.
    modport master (
        output req_valid, req_opcode, req_op1, req_op2, req_op3, rsp_ready,
        output pe_result, pe_result_valid,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  pe_valid_in, pe_opcode, pe_op1, pe_op2, pe_op3
    );

    // Scheduler/arbiter.
    modport slave (
        input  req_valid, req_opcode, req_op1, req_op2, req_op3, rsp_ready,
        input  pe_result, pe_result_valid,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output pe_valid_in, pe_opcode, pe_op1, pe_op2, pe_op3
    );

endinterface

// File: rtl/pe_sched_arbiter_rr_arb.sv
// Round-robin one-hot selector: search starts at rr_ptr+1 and wraps modulo NREQ.
module pe_rr_arb
    import pe_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IdxW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IdxW-1:0] rr_ptr,
    output logic [NREQ-1:0] grant
);

    logic [IdxW-1:0] idx;
    logic            found;

    // Pick the first eligible requester after the last granted one.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IdxW'((int'(rr_ptr) + k) % int'(NREQ));
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_sched_arbiter.sv
// Shares one PE core among NREQ requesters: round-robin issue, a tag pipeline
// that follows each op through the PE latency, and per-requester response
// buffers held until the requester accepts them.
module pe_sched_arbiter
    import pe_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = PeLat
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    pe_sched_arbiter_if.slave bus,
    output logic [15:0]       issue_cnt,
    output logic [15:0]       err_cnt,
    output logic              idle
);

    localparam int unsigned IdxW = idx_width(NREQ);

    logic [NREQ-1:0]    busy_q;
    logic [IdxW-1:0]    rr_ptr_q;
    logic [NREQ-1:0]    eligible;
    logic [NREQ-1:0]    grant;
    logic [IdxW-1:0]    grant_idx;
    logic               issue;
    logic [31:0]        sel_opcode, sel_op1, sel_op2, sel_op3;

    logic [LAT-1:0]     tag_vld_q;
    logic [IdxW-1:0]    tag_idx_q [LAT];
    logic               exit_vld;
    logic [IdxW-1:0]    exit_idx;

    logic [NREQ-1:0]    rsp_valid_q;
    logic [NREQ-1:0]    rsp_err_q;
    logic [NREQ*32-1:0] rsp_data_q;
    logic [15:0]        issue_cnt_q;
    logic [15:0]        err_cnt_q;

    // A requester with a result still pending is not eligible, so at most one
    // op per requester is ever in flight and its buffer is never overwritten.
    assign eligible = bus.req_valid & ~busy_q & {NREQ{en}};

    pe_rr_arb #(
        .NREQ (NREQ),
        .IdxW (IdxW)
    ) u_rr_arb (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_q),
        .grant    (grant)
    );

    assign issue = |grant;

    // Encode the one-hot grant and steer the granted operands to the PE.
    always_comb begin
        grant_idx  = '0;
        sel_opcode = '0;
        sel_op1    = '0;
        sel_op2    = '0;
        sel_op3    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx  = IdxW'(i);
                sel_opcode = bus.req_opcode[32*i +: 32];
                sel_op1    = bus.req_op1[32*i +: 32];
                sel_op2    = bus.req_op2[32*i +: 32];
                sel_op3    = bus.req_op3[32*i +: 32];
            end
        end
    end

    assign bus.req_ready   = grant;
    assign bus.pe_valid_in = issue;
    assign bus.pe_opcode   = sel_opcode;
    assign bus.pe_op1      = sel_op1;
    assign bus.pe_op2      = sel_op2;
    assign bus.pe_op3      = sel_op3;

    // Busy set on issue, cleared on response handshake; pointer follows grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            rr_ptr_q <= IdxW'(NREQ - 1);
        end else begin
            busy_q <= (busy_q & ~(rsp_valid_q & bus.rsp_ready)) | grant;
            if (issue) begin
                rr_ptr_q <= grant_idx;
            end
        end
    end

    // Tag pipeline: shifts every cycle so the tag exits as the PE result lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_idx_q[s] <= '0;
            end
        end else begin
            tag_vld_q[0] <= issue;
            tag_idx_q[0] <= grant_idx;
            for (int s = 1; s < LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_idx_q[s] <= tag_idx_q[s-1];
            end
        end
    end

    assign exit_vld = tag_vld_q[LAT-1];
    assign exit_idx = tag_idx_q[LAT-1];

    // Response buffers: load on tag exit, hold until the requester takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (exit_vld && (exit_idx == IdxW'(i))) begin
                    rsp_valid_q[i]          <= 1'b1;
                    rsp_err_q[i]            <= ~bus.pe_result_valid;
                    rsp_data_q[32*i +: 32]  <= bus.pe_result_valid ? bus.pe_result : 32'd0;
                end else if (bus.rsp_ready[i]) begin
                    rsp_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Wrapping issue and error counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (issue) begin
                issue_cnt_q <= issue_cnt_q + 16'd1;
            end
            if (exit_vld && !bus.pe_result_valid) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;
    assign issue_cnt     = issue_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign idle          = (busy_q == '0) && (tag_vld_q == '0);

endmodule

// File: tb/tb_pe_sched_arbiter.sv
// Bench for pe_sched_arbiter: a stand-in PE core, a transaction-level model of
// the scheduler (who is busy, who is next, when each answer is due), directed
// scenarios followed by a randomized run.
module tb_pe_sched_arbiter;
    import pe_pkg::*;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned LAT   = PeLat;
    localparam logic [31:0] OpAdd = 32'h0210_0000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        en    = 1'b1;
    logic [15:0] issue_cnt;
    logic [15:0] err_cnt;
    logic        idle;

    pe_sched_arbiter_if #(.NREQ(NREQ)) bus ();

    pe_sched_arbiter #(
        .NREQ (NREQ),
        .LAT  (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .bus       (bus),
        .issue_cnt (issue_cnt),
        .err_cnt   (err_cnt),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Requester-side stimulus.
    logic [NREQ-1:0] r_valid = '0;
    logic [NREQ-1:0] r_ready = '1;
    logic [31:0]     r_opc [NREQ];
    logic [31:0]     r_a   [NREQ];
    logic [31:0]     r_b   [NREQ];
    logic [31:0]     r_c   [NREQ];

    always_comb begin
        bus.req_valid = r_valid;
        bus.rsp_ready = r_ready;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_opcode[32*i +: 32] = r_opc[i];
            bus.req_op1[32*i +: 32]    = r_a[i];
            bus.req_op2[32*i +: 32]    = r_b[i];
            bus.req_op3[32*i +: 32]    = r_c[i];
        end
    end

    // Stand-in PE behaviour: {ok, result}.
    function automatic logic [32:0] pe_func(input logic [31:0] opc, a, b, c);
        case (opc[31:25])
            ClsArith: return {1'b1, a + b};
            ClsFpu:   return {1'b1, a ^ b ^ c};
            ClsComp:  return {1'b1, 31'd0, a < b};
            default:  return {1'b0, 32'd0};
        endcase
    endfunction

    // PE core model with LAT-cycle latency; drives noise when idle.
    logic [LAT-1:0] pe_v = '0;
    logic [32:0]    pe_r [LAT];
    logic           noise_v = 1'b0;
    logic [31:0]    noise_d = 32'd0;

    always @(posedge clk) begin
        pe_v[0] <= bus.pe_valid_in;
        pe_r[0] <= pe_func(bus.pe_opcode, bus.pe_op1, bus.pe_op2, bus.pe_op3);
        for (int s = 1; s < LAT; s++) begin
            pe_v[s] <= pe_v[s-1];
            pe_r[s] <= pe_r[s-1];
        end
    end

    assign bus.pe_result_valid = pe_v[LAT-1] ? pe_r[LAT-1][32]   : noise_v;
    assign bus.pe_result       = pe_v[LAT-1] ? pe_r[LAT-1][31:0] : noise_d;

    // Reference model state.
    logic [NREQ-1:0] m_busy;
    logic [NREQ-1:0] m_rspv;
    logic [NREQ-1:0] m_err;
    logic [NREQ-1:0] p_err;
    logic [31:0]     m_data [NREQ];
    logic [31:0]     p_data [NREQ];
    int              m_cnt  [NREQ];
    int              m_rr;
    int              m_issues;
    int              m_errs;
    int              m_grant;
    int              served2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_busy   = '0;
        m_rspv   = '0;
        m_err    = '0;
        p_err    = '0;
        m_rr     = NREQ - 1;
        m_issues = 0;
        m_errs   = 0;
        m_grant  = -1;
        for (int i = 0; i < NREQ; i++) begin
            m_cnt[i]  = 0;
            m_data[i] = '0;
            p_data[i] = '0;
        end
    endtask

    // Compare everything observable against the model at the falling edge.
    task automatic settle();
        int              g;
        logic [NREQ-1:0] exp_ready;
        @(negedge clk);
        g = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_rr + k) % int'(NREQ);
            if (g < 0 && r_valid[idx] && !m_busy[idx] && en) g = idx;
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        chk("pe_valid_in", 32'(bus.pe_valid_in), 32'(g >= 0));
        if (g >= 0) begin
            chk("pe_opcode", bus.pe_opcode, r_opc[g]);
            chk("pe_op1", bus.pe_op1, r_a[g]);
            chk("pe_op2", bus.pe_op2, r_b[g]);
            chk("pe_op3", bus.pe_op3, r_c[g]);
        end else begin
            chk("pe_opcode_nogrant", bus.pe_opcode, 32'd0);
        end
        for (int i = 0; i < NREQ; i++) begin
            chk($sformatf("rsp_valid[%0d]", i), 32'(bus.rsp_valid[i]), 32'(m_rspv[i]));
            if (m_rspv[i]) begin
                chk($sformatf("rsp_data[%0d]", i), bus.rsp_data[32*i +: 32], m_data[i]);
                chk($sformatf("rsp_err[%0d]", i), 32'(bus.rsp_err[i]), 32'(m_err[i]));
            end
        end
        chk("issue_cnt", 32'(issue_cnt), 32'(m_issues[15:0]));
        chk("err_cnt", 32'(err_cnt), 32'(m_errs[15:0]));
        chk("idle", 32'(idle), 32'(m_busy == '0));
        m_grant = g;
    endtask

    // Advance the model by one clock edge, then step past the edge.
    task automatic tick();
        logic [32:0] r;
        for (int i = 0; i < NREQ; i++) begin
            if (m_rspv[i] && r_ready[i]) begin
                m_rspv[i] = 1'b0;
                m_busy[i] = 1'b0;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (m_cnt[i] > 0) begin
                m_cnt[i]--;
                if (m_cnt[i] == 0) begin
                    m_rspv[i] = 1'b1;
                    m_data[i] = p_data[i];
                    m_err[i]  = p_err[i];
                    if (p_err[i]) m_errs++;
                end
            end
        end
        if (m_grant >= 0) begin
            r = pe_func(r_opc[m_grant], r_a[m_grant], r_b[m_grant], r_c[m_grant]);
            p_err[m_grant]  = ~r[32];
            p_data[m_grant] = r[32] ? r[31:0] : 32'd0;
            m_busy[m_grant] = 1'b1;
            m_cnt[m_grant]  = LAT;
            m_rr            = m_grant;
            m_issues++;
        end
        noise_v = 1'($urandom_range(0, 1));
        noise_d = $urandom;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            settle();
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_issue_cnt", 32'(issue_cnt), 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);
        chk("reset_idle", 32'(idle), 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_opc();
        case ($urandom_range(0, 4))
            0:       return OpAdd;
            1:       return {ClsFpu, 25'($urandom)};
            2:       return {ClsComp, 25'($urandom)};
            3:       return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            r_opc[i] = OpAdd;
            r_a[i]   = $urandom_range(0, 1000);
            r_b[i]   = $urandom_range(0, 1000);
            r_c[i]   = $urandom;
        end
        do_reset();

        // All four requesting after reset: grants 0,1,2,3 back to back.
        r_valid = '1;
        r_ready = '1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("rr_order", 32'(bus.req_ready), 32'(1) << k);
            tick();
        end
        r_valid = '0;
        settle();
        chk("issue_cnt_after_4", 32'(issue_cnt), 32'd4);
        tick();
        run(3);

        // ADD 5 + 7 on requester 0.
        r_opc[0] = OpAdd;
        r_a[0]   = 32'd5;
        r_b[0]   = 32'd7;
        r_valid  = 4'b0001;
        settle();
        chk("add_issue_valid", 32'(bus.pe_valid_in), 32'd1);
        chk("add_issue_op1", bus.pe_op1, 32'd5);
        chk("add_issue_op2", bus.pe_op2, 32'd7);
        tick();
        r_valid = '0;
        settle();
        chk("add_rsp_not_yet", 32'(bus.rsp_valid[0]), 32'd0);
        tick();
        settle();
        chk("add_rsp_valid", 32'(bus.rsp_valid[0]), 32'd1);
        chk("add_rsp_data", bus.rsp_data[31:0], 32'd12);
        chk("add_rsp_err", 32'(bus.rsp_err[0]), 32'd0);
        tick();
        run(2);

        // Unknown opcode on requester 1 comes back as an error.
        r_opc[1] = 32'd0;
        r_valid  = 4'b0010;
        settle();
        tick();
        r_valid = '0;
        settle();
        tick();
        settle();
        chk("bad_rsp_err", 32'(bus.rsp_err[1]), 32'd1);
        chk("bad_rsp_data", bus.rsp_data[63:32], 32'd0);
        chk("bad_err_cnt", 32'(err_cnt), 32'd1);
        tick();
        run(2);
        r_opc[1] = OpAdd;

        // Requester 0 stalls its response; requester 2 keeps being served.
        r_opc[0] = OpAdd;
        r_a[0]   = 32'd100;
        r_b[0]   = 32'd23;
        r_valid  = 4'b0101;
        r_ready  = 4'b1110;
        served2  = 0;
        for (int c = 0; c < 14; c++) begin
            settle();
            if (bus.req_ready[2]) served2++;
            if (c >= 4) begin
                chk("stall_rsp_valid0", 32'(bus.rsp_valid[0]), 32'd1);
                chk("stall_rsp_data0", bus.rsp_data[31:0], 32'd123);
                chk("stall_no_regrant0", 32'(bus.req_ready[0]), 32'd0);
            end
            tick();
        end
        chk("stall_req2_served", 32'(served2 > 1), 32'd1);
        r_valid = 4'b0001;
        r_ready = '1;
        settle();
        chk("handshake_cycle_no_grant0", 32'(bus.req_ready[0]), 32'd0);
        tick();
        settle();
        chk("regrant0", 32'(bus.req_ready), 32'b0001);
        tick();
        r_valid = '0;
        run(4);

        // Enable low blocks issue; raising it grants in the same cycle.
        en      = 1'b0;
        r_valid = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("en_low_no_grant", 32'(bus.req_ready), 32'd0);
            tick();
        end
        en = 1'b1;
        settle();
        chk("en_high_grant3", 32'(bus.req_ready), 32'b1000);
        tick();
        r_valid = '0;
        run(3);

        // Reset while a tag is in flight: nothing comes back.
        r_valid = 4'b0010;
        settle();
        tick();
        r_valid = '0;
        rst_n   = 1'b0;
        model_clear();
        #1;
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_idle", 32'(idle), 32'd1);
        chk("midrst_issue_cnt", 32'(issue_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(4);
        chk("postrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("postrst_idle", 32'(idle), 32'd1);
        chk("postrst_err_cnt", 32'(err_cnt), 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                r_valid[i] = ($urandom_range(0, 3) != 0);
                r_ready[i] = ($urandom_range(0, 3) != 0);
                r_opc[i]   = rand_opc();
                r_a[i]     = $urandom;
                r_b[i]     = $urandom;
                r_c[i]     = $urandom;
            end
            en = ($urandom_range(0, 9) != 0);
            settle();
            tick();
        end

        // Drain and confirm the block goes idle.
        r_valid = '0;
        r_ready = '1;
        en      = 1'b1;
        run(LAT + 4);
        chk("final_idle", 32'(idle), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pe_sched_arbiter.md
PE_SCHED_ARBITER -- requirements
Module: pe_sched_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters sharing one pe_core_single.
REQ-002 SHALL have parameter LAT, default 1, meaning the PE result latency in cycles from the issue edge.
REQ-003 SHALL have port clk  in  1  clock.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  in  1  grant enable; when low, no new issue occurs.
REQ-006 SHALL have ports req_valid / req_ready  in / out  NREQ  per-requester request handshake.
REQ-007 SHALL have ports req_opcode, req_op1, req_op2, req_op3  in  NREQ*32 each  flattened operands; requester i occupies bits [32i+31:32i].
REQ-008 SHALL have ports rsp_valid / rsp_ready  out / in  NREQ  per-requester response handshake.
REQ-009 SHALL have ports rsp_data  out  NREQ*32  and rsp_err  out  NREQ  response payload and error flag.
REQ-010 SHALL have ports pe_valid_in, pe_opcode, pe_op1, pe_op2, pe_op3  out  1/32/32/32/32  PE issue bus.
REQ-011 SHALL have ports pe_result, pe_result_valid  in  32/1  PE result bus.
REQ-012 SHALL have ports issue_cnt, err_cnt  out  16 each, and idle  out  1  status.

Function
REQ-013 SHALL keep a registered busy[i] per requester: set on issue, cleared on rsp_valid[i]&&rsp_ready[i].
REQ-014 SHALL treat requester i as eligible when req_valid[i] && !busy[i] && en.
REQ-015 SHALL grant at most one eligible requester per cycle, using round-robin order starting at rr_ptr+1 modulo NREQ.
REQ-016 SHALL drive req_ready as the combinational one-hot grant; the issue occurs in the same cycle.
REQ-017 SHALL drive pe_valid_in = |grant, and pe_opcode/op1/op2/op3 as the granted requester's operands; all are 0 when there is no grant.
REQ-018 SHALL update rr_ptr to the granted index only on a grant.
REQ-019 SHALL shift {valid, index} of each issue into a LAT-deep tag pipeline, advancing every cycle.
REQ-020 SHALL, when a valid tag exits the pipeline at edge E, load response buffer[index] at E: rsp_data = pe_result and rsp_err = 0 if pe_result_valid, else rsp_data = 0 and rsp_err = 1.
REQ-021 SHALL then hold rsp_valid[index] high, with data stable, until rsp_ready[index].
REQ-022 SHALL ignore pe_result_valid when no valid tag is exiting.
REQ-023 SHALL guarantee at most one outstanding operation per requester, so a response buffer is never overwritten.
REQ-024 SHALL support back-to-back issue from different requesters on consecutive cycles (throughput 1 op/cycle).
REQ-025 SHALL have a requester's next grant no earlier than the cycle after its response handshake.
REQ-026 SHALL increment issue_cnt on every issue and err_cnt on every err response load; both wrap at 16 bits.
REQ-027 SHALL drive idle high when busy == 0 and the tag pipeline holds no valid entry.
REQ-028 SHALL let operations in flight complete normally when en deasserts.

Reset
REQ-029 SHALL, on rst_n low (asynchronous), clear busy, tags, rsp_valid, rsp_data, rsp_err, issue_cnt and err_cnt to 0, and set rr_ptr = NREQ-1.
REQ-030 SHALL discard in-flight operations on reset mid-operation; no response is produced for them.

Structure
REQ-031 SHALL take the opcode class constants (0000001 ARITH, 0000010 FPU, 0010000 COMP) and the LAT default from shared package pe_pkg.
REQ-032 SHALL implement the round-robin selector as sub-module pe_rr_arb (inputs: eligible mask, rr_ptr; output: one-hot grant).

Verification
REQ-033 SHALL cover: req0 ADD opcode 0x02100000, op1 = 5, op2 = 7 -> pe_valid_in in the handshake cycle, then rsp_valid[0] two edges later with rsp_data = 12 and rsp_err = 0.
REQ-034 SHALL cover: after reset, all 4 requesters valid with rsp_ready high -> grants in order 0,1,2,3 on consecutive cycles, then issue_cnt = 4.
REQ-035 SHALL cover: req1 opcode 0x00000000 -> rsp_err[1] = 1, rsp_data = 0, err_cnt = 1.
REQ-036 SHALL cover: rsp_ready[0] low for 10 cycles with req0 still valid -> rsp_valid[0] and data held and req0 never re-granted, while req2 is served; req0 is re-granted the cycle after the handshake.
REQ-037 SHALL cover: rst_n pulsed low while a tag is in flight -> no rsp_valid afterwards, idle = 1, and counters = 0.
REQ-038 SHALL cover: en low with req3 valid -> no grant; en high -> grant on the same cycle.
